cic_comb: RTL and testbench

CIC_COMB -- requirements
Module: cic_comb

---
 rtl/cic_pkg.sv | 14 +
 rtl/cic_comb_if.sv | 27 ++
 rtl/cic_comb_delay.sv | 32 +++
 rtl/cic_comb.sv | 78 +++++++
 tb/tb_cic_comb.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/cic_pkg.sv
// Shared CIC definitions: channel count and channel-index type, used by both
// the integrator and comb sides of the filter.
package cic_pkg;

    localparam int NUM_CH = 4;

    typedef logic [1:0] ch_idx_t;

    // Comb differential delay M is only supported as 1 or 2.
    function automatic bit diff_delay_ok(input int m);
        return (m == 1) || (m == 2);
    endfunction

endpackage

// File: rtl/cic_comb_if.sv
// Sample-in / result-out bundle of the CIC comb stage.
interface cic_comb_if #(
    parameter int WIDTH = 64
);
    import cic_pkg::*;

    logic             en_i;
    logic             clr_i;
    ch_idx_t          sel_i;
    logic [WIDTH-1:0] data_i;
    logic [WIDTH-1:0] data_o;
    ch_idx_t          ch_o;
    logic             valid_o;

    // Producer side: drives samples, observes comb results.
    modport master (
        output en_i, clr_i, sel_i, data_i,
        input  data_o, ch_o, valid_o
    );

    // Comb stage side.
    modport slave (
        input  en_i, clr_i, sel_i, data_i,
        output data_o, ch_o, valid_o
    );

endinterface

// File: rtl/cic_comb_delay.sv
// Per-channel comb delay line: DIFF_DELAY words deep, tap_o is the oldest word.
module cic_comb_delay #(
    parameter int WIDTH      = 64,
    parameter int DIFF_DELAY = 1
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             clr_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] tap_o
);

    logic [DIFF_DELAY-1:0][WIDTH-1:0] line;

    // Shift a new word in on each accepted sample; reset and clear zero the line.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            line <= '0;
        end else if (clr_i) begin
            line <= '0;
        end else if (shift_i) begin
            line[0] <= data_i;
            for (int k = 1; k < DIFF_DELAY; k++) begin
                line[k] <= line[k-1];
            end
        end
    end

    assign tap_o = line[DIFF_DELAY-1];

endmodule

// File: rtl/cic_comb.sv
// Four-channel time-multiplexed CIC comb: y = x[n] - x[n-M] per channel,
// with a per-channel fill count so results only flow once the line is primed.
module cic_comb
    import cic_pkg::*;
#(
    parameter int WIDTH      = 64,
    parameter int DIFF_DELAY = 1
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    cic_comb_if.slave     bus
);

    localparam int FW = $clog2(DIFF_DELAY + 1);

    generate
        if (!diff_delay_ok(DIFF_DELAY)) begin : g_bad_delay
            $fatal(1, "cic_comb: DIFF_DELAY must be 1 or 2");
        end
    endgenerate

    logic                         accept;
    logic [NUM_CH-1:0]            shift;
    logic [NUM_CH-1:0][WIDTH-1:0] tap;
    logic [NUM_CH-1:0][FW-1:0]    fill;
    logic                         primed;
    logic [WIDTH-1:0]             diff;

    // A clear discards any sample presented in the same cycle.
    assign accept = bus.en_i & ~bus.clr_i;
    assign primed = (fill[bus.sel_i] == FW'(DIFF_DELAY));
    assign diff   = bus.data_i - tap[bus.sel_i];

    // One-hot shift strobe towards the selected channel's delay line.
    always_comb begin
        shift = '0;
        shift[bus.sel_i] = accept;
    end

    cic_comb_delay #(
        .WIDTH      (WIDTH),
        .DIFF_DELAY (DIFF_DELAY)
    ) u_dly [NUM_CH-1:0] (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .clr_i   (bus.clr_i),
        .shift_i (shift),
        .data_i  (bus.data_i),
        .tap_o   (tap)
    );

    // Count samples into each channel until its delay line holds real history.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            fill <= '0;
        end else if (bus.clr_i) begin
            fill <= '0;
        end else if (accept && !primed) begin
            fill[bus.sel_i] <= fill[bus.sel_i] + FW'(1);
        end
    end

    // Register the comb result; data/channel hold when nothing valid is produced.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            bus.data_o  <= '0;
            bus.ch_o    <= '0;
            bus.valid_o <= 1'b0;
        end else begin
            bus.valid_o <= accept & primed;
            if (accept && primed) begin
                bus.data_o <= diff;
                bus.ch_o   <= bus.sel_i;
            end
        end
    end

endmodule

// File: tb/tb_cic_comb.sv
// Bench for cic_comb: three instances (W64/M1, W8/M1, W64/M2) driven from one
// directed sequence; a reference model pushes expected outputs to a scoreboard
// queue each cycle, popped and compared after the clock edge.
module tb_cic_comb;
    import cic_pkg::*;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    cic_comb_if #(.WIDTH(64)) if0 ();
    cic_comb_if #(.WIDTH(8))  if1 ();
    cic_comb_if #(.WIDTH(64)) if2 ();

    cic_comb #(.WIDTH(64), .DIFF_DELAY(1)) u_dut0 (.clk_i(clk), .rstn_i(rstn), .bus(if0.slave));
    cic_comb #(.WIDTH(8),  .DIFF_DELAY(1)) u_dut1 (.clk_i(clk), .rstn_i(rstn), .bus(if1.slave));
    cic_comb #(.WIDTH(64), .DIFF_DELAY(2)) u_dut2 (.clk_i(clk), .rstn_i(rstn), .bus(if2.slave));

    typedef struct {
        logic        v;
        logic [63:0] d;
        logic [1:0]  c;
    } exp_t;

    exp_t sb[$];

    int checks   = 0;
    int failures = 0;

    int          mw [3] = '{64, 8, 64};
    int          mm [3] = '{1, 1, 2};
    logic [63:0] m_dly [3][4][2];
    int          m_fill [3][4];
    logic [63:0] m_d [3];
    logic [1:0]  m_c [3];

    function automatic logic [63:0] wmask(input int w);
        logic [63:0] one;
        one = 64'd1;
        return (w >= 64) ? {64{1'b1}} : ((one << w) - 64'd1);
    endfunction

    // Reference behaviour of one instance for one clock edge.
    task automatic model_step(input int k, input bit en, input bit clr,
                              input logic [1:0] sel, input logic [63:0] din);
        exp_t        e;
        logic [63:0] x, y;
        x = din & wmask(mw[k]);
        e.v = 1'b0;
        if (!rstn || clr) begin
            for (int c = 0; c < 4; c++) begin
                m_fill[k][c] = 0;
                m_dly[k][c][0] = '0;
                m_dly[k][c][1] = '0;
            end
            if (!rstn) begin
                m_d[k] = '0;
                m_c[k] = '0;
            end
        end else if (en) begin
            y = (x - m_dly[k][sel][mm[k]-1]) & wmask(mw[k]);
            if (m_fill[k][sel] == mm[k]) begin
                e.v    = 1'b1;
                m_d[k] = y;
                m_c[k] = sel;
            end else begin
                m_fill[k][sel] = m_fill[k][sel] + 1;
            end
            m_dly[k][sel][1] = m_dly[k][sel][0];
            m_dly[k][sel][0] = x;
        end
        e.d = m_d[k];
        e.c = m_c[k];
        sb.push_back(e);
    endtask

    task automatic get_obs(input int k, output logic v, output logic [63:0] d,
                           output logic [1:0] c);
        case (k)
            0:       begin v = if0.valid_o; d = if0.data_o;         c = if0.ch_o; end
            1:       begin v = if1.valid_o; d = {56'd0, if1.data_o}; c = if1.ch_o; end
            default: begin v = if2.valid_o; d = if2.data_o;         c = if2.ch_o; end
        endcase
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Directed check of one instance against fixed expected values.
    task automatic chk_out(input string tag, input int k, input logic v,
                           input logic [63:0] d, input logic [1:0] c);
        logic        ov;
        logic [63:0] od;
        logic [1:0]  oc;
        get_obs(k, ov, od, oc);
        chk({tag, "_valid"}, {63'd0, ov}, {63'd0, v});
        if (v) begin
            chk({tag, "_data"}, od, d);
            chk({tag, "_ch"}, {62'd0, oc}, {62'd0, c});
        end
    endtask

    // Drive one cycle: instance d gets the sample, the others idle. k=-1 idles all.
    task automatic cycle(input int d, input bit en, input bit clr,
                         input logic [1:0] sel, input logic [63:0] din);
        exp_t        e;
        logic        ov;
        logic [63:0] od;
        logic [1:0]  oc;
        if0.en_i = (d == 0) && en; if0.clr_i = (d == 0) && clr; if0.sel_i = sel; if0.data_i = din;
        if1.en_i = (d == 1) && en; if1.clr_i = (d == 1) && clr; if1.sel_i = sel; if1.data_i = din[7:0];
        if2.en_i = (d == 2) && en; if2.clr_i = (d == 2) && clr; if2.sel_i = sel; if2.data_i = din;
        for (int k = 0; k < 3; k++) begin
            model_step(k, (d == k) && en, (d == k) && clr, sel, din);
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            e = sb.pop_front();
            get_obs(k, ov, od, oc);
            chk($sformatf("sb%0d_valid", k), {63'd0, ov}, {63'd0, e.v});
            chk($sformatf("sb%0d_data", k), od, e.d);
            chk($sformatf("sb%0d_ch", k), {62'd0, oc}, {62'd0, e.c});
        end
    endtask

    initial begin
        rstn = 1'b0;
        cycle(-1, 0, 0, 0, 0);
        cycle(-1, 0, 0, 0, 0);
        chk_out("reset", 0, 0, 0, 0);
        chk_out("reset_d", 0, 1'b0, 0, 0);
        chk("reset_data0", if0.data_o, 64'd0);
        rstn = 1'b1;

        // M=1 basic: first sample primes, then differences of 15
        cycle(0, 1, 0, 0, 10);
        chk_out("m1_prime", 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 25);
        chk_out("m1_s2", 0, 1, 15, 0);
        cycle(0, 1, 0, 0, 40);
        chk_out("m1_s3", 0, 1, 15, 0);

        // 8-bit wrap-around
        cycle(1, 1, 0, 1, 64'hF0);
        chk_out("wrap_prime", 1, 0, 0, 0);
        cycle(1, 1, 0, 1, 64'h10);
        chk_out("wrap", 1, 1, 64'h20, 1);

        // M=2 round-robin interleave over four channels
        for (int n = 0; n < 4; n++) begin
            for (int c = 0; c < 4; c++) begin
                cycle(2, 1, 0, c[1:0], 64'(100 * c + n));
                if (n >= 2) chk_out($sformatf("ilv_c%0d_n%0d", c, n), 2, 1, 2, c[1:0]);
                else        chk_out($sformatf("ilv_c%0d_n%0d", c, n), 2, 0, 0, 0);
            end
        end

        // clear with a simultaneous sample on primed ch2
        cycle(0, 1, 0, 2, 5);
        cycle(0, 1, 0, 2, 6);
        chk_out("clr_pre", 0, 1, 1, 2);
        cycle(0, 1, 1, 2, 99);
        chk_out("clr", 0, 0, 0, 0);
        chk("clr_hold", if0.data_o, 64'd1);
        cycle(0, 1, 0, 2, 7);
        chk_out("clr_reprime", 0, 0, 0, 0);
        cycle(0, 1, 0, 2, 9);
        chk_out("clr_after", 0, 1, 2, 2);

        // inputs ignored without en
        cycle(0, 0, 0, 3, 64'hDEAD);
        chk_out("noen", 0, 0, 0, 0);
        chk("noen_hold", if0.data_o, 64'd2);

        // random back-to-back traffic on the 8-bit instance
        for (int i = 0; i < 12; i++) begin
            cycle(1, 1, 0, 2'($urandom_range(0, 3)), 64'($urandom_range(0, 255)));
        end

        // reset mid-stream
        cycle(2, 1, 0, 1, 500);
        rstn = 1'b0;
        cycle(2, 1, 0, 1, 600);
        chk_out("rst_mid2", 2, 0, 0, 0);
        chk("rst_mid2_data", if2.data_o, 64'd0);
        chk("rst_mid0_data", if0.data_o, 64'd0);
        rstn = 1'b1;
        cycle(2, 1, 0, 1, 700);
        chk_out("rst_re1", 2, 0, 0, 0);
        cycle(2, 1, 0, 1, 710);
        chk_out("rst_re2", 2, 0, 0, 0);
        cycle(2, 1, 0, 1, 720);
        chk_out("rst_re3", 2, 1, 20, 1);
        cycle(0, 1, 0, 0, 3);
        chk_out("rst_re0a", 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 8);
        chk_out("rst_re0b", 0, 1, 5, 0);
        cycle(-1, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
